// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stage-tagged stall requests into
// stall/bubble/flush vectors, debug halt/step FSM, perf counters, watchdog.
module pipe_stall_ctrl #(
    parameter int                      NSTAGE    = 5,
    parameter int                      NREQ      = 3,
    parameter int                      IDX_W     = 3,
    parameter logic [NREQ*IDX_W-1:0]   REQ_STAGE = {3'd3, 3'd1, 3'd0},
    parameter int                      CNT_W     = 32,
    parameter int                      WDOG      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stallreq,
    input  logic              flush_req,
    input  logic [IDX_W-1:0]  flush_stage,
    input  logic              halt_req,
    input  logic              step,
    input  logic              resume,
    input  logic              cnt_clr,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              flush_ack,
    output logic              halted,
    output logic              hang,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;

    localparam int WD_W = (WDOG > 1) ? $clog2(WDOG + 1) : 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [WD_W-1:0]   r_wd;
    logic [WD_W-1:0]   w_wd_nxt;
    logic              r_hang;

    logic              w_any;
    logic [IDX_W-1:0]  w_m;
    logic              w_dbg;
    logic [NSTAGE-1:0] w_hz;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_bubble;
    logic [NSTAGE-1:0] w_flush;
    logic              w_fs_ok;
    logic              w_tgt_stall;
    logic              w_ack;
    logic              w_wd_hit;

    // Deepest active requester decides how far back the pipe must hold.
    always_comb begin
        w_any = 1'b0;
        w_m   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (stallreq[k]) begin
                if (!w_any || (REQ_STAGE[k*IDX_W +: IDX_W] > w_m)) begin
                    w_m = REQ_STAGE[k*IDX_W +: IDX_W];
                end
                w_any = 1'b1;
            end
        end
    end

    assign w_dbg = (r_state == S_HALT);

    always_comb begin
        w_hz = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            w_hz[i] = w_any && (IDX_W'(i) <= w_m);
        end
    end

    assign w_stall = w_hz | {NSTAGE{w_dbg}};

    always_comb begin
        w_fs_ok     = (int'(flush_stage) < NSTAGE);
        w_tgt_stall = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (IDX_W'(i) == flush_stage) begin
                w_tgt_stall = w_stall[i];
            end
        end
    end

    assign w_ack = flush_req && !w_tgt_stall;

    always_comb begin
        w_flush = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            w_flush[i] = w_ack && w_fs_ok && (IDX_W'(i) <= flush_stage);
        end
    end

    // The stage just past the stall point takes a NOP unless flushed.
    always_comb begin
        w_bubble = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            w_bubble[i] = w_any && !w_dbg && (w_m == IDX_W'(i - 1));
        end
        w_bubble = w_bubble & ~w_flush;
    end

    assign stall     = rst ? w_stall  : '0;
    assign bubble    = rst ? w_bubble : '0;
    assign flush     = rst ? w_flush  : '0;
    assign flush_ack = rst && w_ack;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN:   if (halt_req) w_state_nxt = S_HALT;
            S_HALT: begin
                if (resume)    w_state_nxt = S_RUN;
                else if (step) w_state_nxt = S_STEP;
            end
            S_STEP:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_any && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ack && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Debug halt freezes the watchdog rather than restarting it.
    always_comb begin
        w_wd_nxt = r_wd;
        if (!w_any) begin
            w_wd_nxt = '0;
        end else if (!w_dbg && (r_wd != WD_W'(WDOG))) begin
            w_wd_nxt = r_wd + WD_W'(1);
        end
    end

    assign w_wd_hit = (WDOG != 0) && (w_wd_nxt == WD_W'(WDOG));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd   <= '0;
            r_hang <= 1'b0;
        end else if (cnt_clr) begin
            r_wd   <= '0;
            r_hang <= 1'b0;
        end else begin
            r_wd   <= w_wd_nxt;
            r_hang <= r_hang | w_wd_hit;
        end
    end

    assign halted    = w_dbg;
    assign hang      = r_hang;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with small counters and a short
// watchdog so saturation and hang are reachable quickly.
module tb_pipe_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] stallreq;
    logic       flush_req;
    logic [2:0] flush_stage;
    logic       halt_req;
    logic       step;
    logic       resume;
    logic       cnt_clr;
    logic [4:0] stall;
    logic [4:0] bubble;
    logic [4:0] flush;
    logic       flush_ack;
    logic       halted;
    logic       hang;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int n_checks;
    int n_fail;

    pipe_stall_ctrl #(
        .NSTAGE(5), .NREQ(3), .IDX_W(3),
        .REQ_STAGE({3'd3, 3'd1, 3'd0}),
        .CNT_W(4), .WDOG(4)
    ) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq),
        .flush_req(flush_req), .flush_stage(flush_stage),
        .halt_req(halt_req), .step(step), .resume(resume),
        .cnt_clr(cnt_clr), .stall(stall), .bubble(bubble),
        .flush(flush), .flush_ack(flush_ack), .halted(halted),
        .hang(hang), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; stallreq = 3'b111; flush_req = 1'b1;
        flush_stage = 3'd2; halt_req = 1'b0; step = 1'b0;
        resume = 1'b0; cnt_clr = 1'b0;
        #2;
        n_checks++;
        if (stall !== 5'b00000) begin
            n_fail++; $display("FAIL rst_stall got=%b exp=00000", stall);
        end
        n_checks++;
        if (bubble !== 5'b00000 || flush !== 5'b00000 || flush_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_comb got b=%b f=%b a=%b exp 0", bubble, flush, flush_ack);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || halted !== 1'b0 || hang !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_regs got sc=%0d fc=%0d h=%b hg=%b exp 0",
                     stall_cnt, flush_cnt, halted, hang);
        end
        @(negedge clk);
        rst = 1'b1; stallreq = 3'b100; flush_req = 1'b0;
        #1;
        n_checks++;
        if (stall !== 5'b01111) begin
            n_fail++; $display("FAIL rel_stall got=%b exp=01111", stall);
        end
        n_checks++;
        if (bubble !== 5'b10000) begin
            n_fail++; $display("FAIL rel_bubble got=%b exp=10000", bubble);
        end
    endtask

    task automatic test_priority;
        @(negedge clk);
        stallreq = 3'b011;
        #1;
        n_checks++;
        if (stall !== 5'b00011 || bubble !== 5'b00100) begin
            n_fail++;
            $display("FAIL prio_lo got s=%b b=%b exp s=00011 b=00100", stall, bubble);
        end
        @(negedge clk);
        stallreq = 3'b111;
        #1;
        n_checks++;
        if (stall !== 5'b01111 || bubble !== 5'b10000) begin
            n_fail++;
            $display("FAIL prio_hi got s=%b b=%b exp s=01111 b=10000", stall, bubble);
        end
        n_checks++;
        if (stall_cnt !== 4'd2) begin
            n_fail++; $display("FAIL prio_cnt got=%0d exp=2", stall_cnt);
        end
        @(negedge clk);
        stallreq = 3'b000;
        #1;
        n_checks++;
        if (stall !== 5'b00000 || bubble !== 5'b00000) begin
            n_fail++;
            $display("FAIL prio_none got s=%b b=%b exp 0", stall, bubble);
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        stallreq = 3'b100; flush_req = 1'b1; flush_stage = 3'd2;
        #1;
        chk("fl_clr_sc", {4'd0, stall_cnt}, 8'd0);
        n_checks++;
        if (flush !== 5'b00000 || flush_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_blocked got f=%b a=%b exp f=00000 a=0", flush, flush_ack);
        end
        @(negedge clk);
        stallreq = 3'b000;
        #1;
        n_checks++;
        if (flush !== 5'b00110 || flush_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_accept got f=%b a=%b exp f=00110 a=1", flush, flush_ack);
        end
        @(posedge clk);
        #1;
        chk("fl_cnt1", {4'd0, flush_cnt}, 8'd1);
        chk("fl_sc1", {4'd0, stall_cnt}, 8'd1);
        @(negedge clk);
        stallreq = 3'b010;
        #1;
        n_checks++;
        if (stall !== 5'b00011 || flush !== 5'b00110 || bubble !== 5'b00000 || flush_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_over_bub got s=%b f=%b b=%b a=%b exp s=00011 f=00110 b=00000 a=1",
                     stall, flush, bubble, flush_ack);
        end
        @(negedge clk);
        stallreq = 3'b000; flush_stage = 3'd7;
        #1;
        n_checks++;
        if (flush !== 5'b00000 || flush_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_oob got f=%b a=%b exp f=00000 a=1", flush, flush_ack);
        end
        @(negedge clk);
        flush_stage = 3'd0;
        #1;
        n_checks++;
        if (flush !== 5'b00000 || flush_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_stage0 got f=%b a=%b exp f=00000 a=1", flush, flush_ack);
        end
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        chk("fl_cnt4", {4'd0, flush_cnt}, 8'd4);
    endtask

    task automatic test_debug;
        @(negedge clk);
        halt_req = 1'b1;
        #1;
        n_checks++;
        if (stall !== 5'b00000 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_halt_cyc got s=%b h=%b exp s=00000 h=0", stall, halted);
        end
        @(negedge clk);
        halt_req = 1'b0; stallreq = 3'b100;
        flush_req = 1'b1; flush_stage = 3'd2;
        #1;
        n_checks++;
        if (stall !== 5'b11111 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL dbg_halted got s=%b h=%b exp s=11111 h=1", stall, halted);
        end
        n_checks++;
        if (bubble !== 5'b00000 || flush_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_bub_fl got b=%b a=%b exp b=00000 a=0", bubble, flush_ack);
        end
        repeat (6) @(negedge clk);
        #1;
        chk("dbg_wd_frozen", {7'd0, hang}, 8'd0);
        stallreq = 3'b000; flush_req = 1'b0;
        @(negedge clk);
        step = 1'b1;
        #1;
        chk("dbg_step_pre", {3'd0, stall}, 8'b00011111);
        @(negedge clk);
        step = 1'b0;
        #1;
        n_checks++;
        if (stall !== 5'b00000 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_step got s=%b h=%b exp s=00000 h=0", stall, halted);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 5'b11111 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL dbg_rehalt got s=%b h=%b exp s=11111 h=1", stall, halted);
        end
        @(negedge clk);
        resume = 1'b1; step = 1'b1;
        @(negedge clk);
        resume = 1'b0; step = 1'b0;
        #1;
        n_checks++;
        if (stall !== 5'b00000 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL dbg_resume got s=%b h=%b exp s=00000 h=0", stall, halted);
        end
        @(negedge clk);
        #1;
        chk("dbg_run_stay", {7'd0, halted}, 8'd0);
    endtask

    task automatic test_watchdog;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0; stallreq = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        chk("wd_pre", {7'd0, hang}, 8'd0);
        @(posedge clk);
        #1;
        chk("wd_set", {7'd0, hang}, 8'd1);
        chk("wd_sc", {4'd0, stall_cnt}, 8'd4);
        @(negedge clk);
        stallreq = 3'b000;
        @(posedge clk);
        #1;
        chk("wd_sticky", {7'd0, hang}, 8'd1);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (hang !== 1'b0 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL wd_clr got hg=%b sc=%0d exp hg=0 sc=0", hang, stall_cnt);
        end
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_saturation;
        @(negedge clk);
        stallreq = 3'b100;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_sc", {4'd0, stall_cnt}, 8'h0F);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 4'd0 || hang !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clr got sc=%0d hg=%b exp sc=0 hg=0", stall_cnt, hang);
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_after", {4'd0, stall_cnt}, 8'd1);
        @(negedge clk);
        stallreq = 3'b000;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        chk("ar_halted", {7'd0, halted}, 8'd1);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0 || stall !== 5'b00000 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL ar_clear got h=%b s=%b sc=%0d exp h=0 s=0 sc=0",
                     halted, stall, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_priority;
        test_flush;
        test_debug;
        test_watchdog;
        test_saturation;
        test_async_reset;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Parametrised pipeline hazard controller for the RISC-V core; successor to the fixed 5-stage stall controller.
- Merges N stage-tagged stall requests into a stall vector, plus a bubble vector, a flush vector and a debug halt/single-step FSM.
- Adds saturating stall/flush performance counters and a stall watchdog.
- Sits beside the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb); drives their hold, clear and bubble inputs.

Parameters:
- NSTAGE, 5: number of pipeline stages; stage 0 = PC/IF.
- NREQ, 3: number of stall requesters.
- IDX_W, 3: stage index width; must be at least clog2(NSTAGE).
- REQ_STAGE, {3'd3,3'd1,3'd0}: packed NREQ*IDX_W stage index per requester; requester 0 sits in the LSBs. Default: req0 = IF/icache, req1 = ID load-use, req2 = MEM.
- CNT_W, 32: performance counter width.
- WDOG, 1024: consecutive-stall cycles before the hang flag sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq  in  NREQ  level stall request, one bit per requester.
- flush_req  in  1  flush request, e.g. branch/jump resolved.
- flush_stage  in  IDX_W  stage issuing the flush.
- halt_req  in  1  debug halt pulse.
- step  in  1  debug single-step pulse.
- resume  in  1  debug resume pulse.
- cnt_clr  in  1  synchronous clear of the counters and hang flag.
- stall  out  NSTAGE  stall[i]=1: stage i holds its register.
- bubble  out  NSTAGE  bubble[i]=1: the register feeding stage i loads a NOP.
- flush  out  NSTAGE  flush[i]=1: the register feeding stage i is cleared.
- flush_ack  out  1  flush accepted this cycle.
- halted  out  1  FSM in HALT.
- hang  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  cycles with at least one stallreq active.
- flush_cnt  out  CNT_W  accepted flushes.

Behaviour:
- Reset (rst=0, asynchronous): FSM=RUN, halted=0, hang=0, both counters=0, watchdog count=0.
- While rst=0, the combinational outputs stall, bubble, flush and flush_ack are forced to 0.
- Hazard stall (combinational, zero latency):
  - m = maximum REQ_STAGE[k] over all active stallreq[k].
  - hz_stall[i] = 1 for i <= m, else 0. Example: a MEM request (m=3) gives 5'b01111.
  - No active request: hz_stall = 0.
- Bubble: if a request is active and m < NSTAGE-1, then bubble[m+1]=1; all other bits 0. Bubble is 0 while debug-stalled.
- Debug FSM, states RUN, HALT, STEP:
  - RUN: halt_req -> HALT next cycle. step and resume are ignored.
  - HALT: resume -> RUN; else step -> STEP; else stay. Resume beats step.
  - STEP: unconditionally -> HALT after one cycle. This releases exactly one pipeline advance.
  - dbg_stall = all ones in HALT; 0 in RUN and STEP.
  - Entering HALT takes one cycle: the cycle carrying halt_req still advances.
- Output stall = hz_stall OR dbg_stall. halted = (state==HALT).
- Flush:
  - Accepted when flush_req=1 and stall[flush_stage]=0.
  - When accepted: flush_ack=1 and flush[i]=1 for 1 <= i <= flush_stage. Example: an EX (stage 2) flush clears the IF/ID and ID/EX inputs.
  - When not accepted: flush=0, flush_ack=0. The requester must hold flush_req until it sees flush_ack.
  - flush_stage=0 or flush_stage >= NSTAGE is accepted with flush=0.
  - If a bit is both flushed and bubbled, flush wins and that bubble bit is 0.
- Counters (registered):
  - stall_cnt increments on every cycle with stallreq != 0, debug state irrelevant.
  - flush_cnt increments on every flush_ack.
  - Both saturate at all ones.
  - cnt_clr takes priority over increment.
- Watchdog:
  - Internal count increments while stallreq != 0 and resets to 0 on any cycle with stallreq == 0.
  - When the count reaches WDOG, hang is set and stays 1 until cnt_clr or reset.
  - Debug HALT does not advance the watchdog.
  - WDOG=0: hang is never set.

Test Plan:
- Reset: rst=0 with stallreq=3'b111 -> stall=0, bubble=0, counters=0. Release, then stallreq=3'b100 -> stall=5'b01111, bubble=5'b10000.
- Priority: stallreq=3'b011 (stages 0 and 1) -> stall=5'b00011, bubble=5'b00100. Add req2 -> stall=5'b01111, bubble=5'b10000.
- Flush blocked by stall:
  - flush_req=1, flush_stage=2, stallreq=3'b100 -> flush=0, flush_ack=0.
  - Drop stallreq -> same cycle flush=5'b00110, flush_ack=1; flush_cnt increments to 1.
- Debug:
  - halt_req pulse -> next cycle stall=5'b11111, halted=1.
  - step pulse -> following cycle stall=0, halted=0; then back to 5'b11111.
  - resume and step together in HALT -> RUN.
- Watchdog (WDOG=4): stallreq=3'b001 held for 4 cycles -> hang=1; hang stays 1 after stallreq drops; cnt_clr -> hang=0, stall_cnt=0.
- Saturation (CNT_W=4): 20 stalled cycles -> stall_cnt=4'hF. cnt_clr asserted together with an active stall -> stall_cnt=0 next cycle.
